// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Owner indices, request masks, FSM states and the read-return tag.
package sram_arb_pkg;

  localparam int unsigned NUM_REQ        = 3;
  localparam int unsigned OWNER_W        = 2;
  localparam int unsigned REQ_LOADER     = 0;
  localparam int unsigned REQ_ESTIMATOR  = 1;
  localparam int unsigned REQ_SERIALIZER = 2;

  typedef logic [OWNER_W-1:0] owner_t;
  typedef logic [NUM_REQ-1:0] req_mask_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // One entry of the read-return pipeline.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rtag_t;

  function automatic owner_t onehot_to_owner(input req_mask_t oh);
    owner_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = owner_t'(i);
    end
    return idx;
  endfunction

  // Successor of an owner index, modulo NUM_REQ.
  function automatic owner_t next_owner(input owner_t o);
    return (o >= owner_t'(NUM_REQ - 1)) ? '0 : o + owner_t'(1);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of one arbitrated SRAM port.
// Requester slot i occupies bits [i*W +: W] of the packed addr/wdata vectors.
interface sram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
);
  import sram_arb_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  logic                          sram_cs;
  logic                          sram_we;
  logic [ADDR_WIDTH-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [DATA_WIDTH-1:0]         sram_rdata;

  // Requesters plus the SRAM macro as seen from outside the arbiter.
  modport master (
    output req, we, addr, wdata, sram_rdata,
    input  gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  req, we, addr, wdata, sram_rdata,
    output gnt, rvalid, rdata, sram_cs, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible request searching
// upward from last_owner+1 modulo NUM_REQ.
module rr_picker
  import sram_arb_pkg::*;
(
  input  req_mask_t req,
  input  owner_t    last_owner,
  input  req_mask_t exclude,
  output req_mask_t pick,
  output logic      valid
);

  req_mask_t cand;
  owner_t    idx;

  always_comb begin
    cand = req & ~exclude;
    pick = '0;
    idx  = last_owner;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = next_owner(idx);
      if ((pick == '0) && cand[idx]) pick[idx] = 1'b1;
    end
    valid = |cand;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Three-way round-robin arbiter for a single-port SRAM with burst lock,
// optional burst cap, and tagged read return to the issuing requester.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 256
) (
  input logic               clk,
  input logic               rst_n,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  req_mask_t         gnt_q, gnt_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  req_mask_t         pick;
  logic              pick_vld;
  logic              contended;
  logic              cap_hit;

  logic              access;
  logic              we_c;

  rtag_t             pipe_q [READ_LATENCY];
  rtag_t             tag_in;
  req_mask_t         rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // The current owner is excluded so a release or a cap revocation moves on.
  rr_picker u_picker (
    .req        (bus.req),
    .last_owner (last_q),
    .exclude    (gnt_q),
    .pick       (pick),
    .valid      (pick_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= owner_t'(REQ_SERIALIZER);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    contended = |(bus.req & ~gnt_q);
    cap_hit   = (MAX_BURST != 0) && contended &&
                (cnt_q == CNT_W'(MAX_BURST - 1));

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWNED;
          gnt_d   = pick;
          owner_d = onehot_to_owner(pick);
          last_d  = onehot_to_owner(pick);
          cnt_d   = '0;
        end
      end
      OWNED: begin
        if (bus.req[owner_q] && !cap_hit) begin
          if (contended && (MAX_BURST != 0)) cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_vld) begin
          // Handover in the same edge, no idle bubble.
          gnt_d   = pick;
          owner_d = onehot_to_owner(pick);
          last_d  = onehot_to_owner(pick);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM port mux; address and data are zeroed when no access is taking place.
  always_comb begin
    access = |(gnt_q & bus.req);
    we_c   = access & bus.we[owner_q];
  end

  assign bus.sram_cs    = access;
  assign bus.sram_we    = we_c;
  assign bus.sram_addr  = access ? bus.addr[32'(owner_q) * ADDR_WIDTH +: ADDR_WIDTH]
                                 : '0;
  assign bus.sram_wdata = access ? bus.wdata[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH]
                                 : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = access & ~we_c;
    tag_in.owner = owner_q;
    rvalid_d     = '0;
    if (pipe_q[READ_LATENCY-1].valid) rvalid_d[pipe_q[READ_LATENCY-1].owner] = 1'b1;
  end

  // Read tags ride alongside the SRAM latency; rvalid_q is the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      rvalid_q <= rvalid_d;
      rdata_q  <= bus.sram_rdata;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;
  localparam int unsigned RL = 1;
  localparam int unsigned MB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   own;

  sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_port_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .MAX_BURST    (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q = '0;

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
      else             rd_q <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[s]                = w;
    bus.addr[s*AW +: AW]     = a;
    bus.wdata[s*DW +: DW]    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",    32'(bus.gnt), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata",  32'(bus.rdata), 32'h0);
    check("rst_cs",     32'(bus.sram_cs), 32'h0);
    check("rst_we",     32'(bus.sram_we), 32'h0);
    check("rst_addr",   32'(bus.sram_addr), 32'h0);
    check("rst_wdata",  32'(bus.sram_wdata), 32'h0);
    rst_n = 1'b1;
    step();

    // Loader write burst to addresses 0..9
    bus.req = 3'b001;
    set_slot(REQ_LOADER, 1'b1, '0, 16'h0100);
    #1;
    check("t1_pre_cs", 32'(bus.sram_cs), 32'h0);
    step();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 10; i++) begin
      set_slot(REQ_LOADER, 1'b1, AW'(i), DW'(32'h0100 + 32'(i)));
      #1;
      check("t1_cs",     32'(bus.sram_cs), 32'h1);
      check("t1_we",     32'(bus.sram_we), 32'h1);
      check("t1_addr",   32'(bus.sram_addr), 32'(i));
      check("t1_wdata",  32'(bus.sram_wdata), 32'h0100 + 32'(i));
      check("t1_rvalid", 32'(bus.rvalid), 32'h0);
      step();
    end
    bus.req = '0; bus.we = '0;
    #1;
    check("t1_end_cs", 32'(bus.sram_cs), 32'h0);
    step();
    check("t1_idle_gnt", 32'(bus.gnt), 32'h0);
    for (int i = 0; i < 10; i++) check("t1_mem", 32'(mem[i]), 32'h0100 + 32'(i));

    // Serializer reads 5,6 then hands over to the waiting estimator
    bus.req = 3'b100;
    set_slot(REQ_SERIALIZER, 1'b0, 12'd5, '0);
    step();
    check("t2_gnt_ser", 32'(bus.gnt), 32'h4);
    bus.req = 3'b110;
    set_slot(REQ_ESTIMATOR, 1'b0, 12'd7, '0);
    #1;
    check("t2_cs_a1",   32'(bus.sram_cs), 32'h1);
    check("t2_addr_a1", 32'(bus.sram_addr), 32'd5);
    check("t2_we_a1",   32'(bus.sram_we), 32'h0);
    step();
    set_slot(REQ_SERIALIZER, 1'b0, 12'd6, '0);
    #1;
    check("t2_addr_a2",   32'(bus.sram_addr), 32'd6);
    check("t2_rvalid_a2", 32'(bus.rvalid), 32'h0);
    step();
    bus.req = 3'b010;
    check("t2_rvalid_a3", 32'(bus.rvalid), 32'h4);
    check("t2_rdata_a3",  32'(bus.rdata), 32'h0105);
    check("t2_gnt_a3",    32'(bus.gnt), 32'h4);
    step();
    check("t2_gnt_est",   32'(bus.gnt), 32'h2);
    check("t2_rvalid_a4", 32'(bus.rvalid), 32'h4);
    check("t2_rdata_a4",  32'(bus.rdata), 32'h0106);
    #1;
    check("t2_cs_a4",     32'(bus.sram_cs), 32'h1);
    check("t2_addr_a4",   32'(bus.sram_addr), 32'd7);
    step();
    bus.req = '0;
    check("t2_rvalid_a5", 32'(bus.rvalid), 32'h0);
    step();
    check("t2_rvalid_a6", 32'(bus.rvalid), 32'h2);
    check("t2_rdata_a6",  32'(bus.rdata), 32'h0107);
    check("t2_gnt_a6",    32'(bus.gnt), 32'h0);
    step();
    check("t2_rvalid_a7", 32'(bus.rvalid), 32'h0);

    // Reset with loader reads in flight
    bus.req = 3'b001;
    set_slot(REQ_LOADER, 1'b0, 12'd1, '0);
    step();
    check("t5_gnt", 32'(bus.gnt), 32'h1);
    step();
    set_slot(REQ_LOADER, 1'b0, 12'd2, '0);
    bus.req = 3'b111;
    #1;
    check("t5_cs_pre", 32'(bus.sram_cs), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_gnt_rst",    32'(bus.gnt), 32'h0);
    check("t5_rvalid_rst", 32'(bus.rvalid), 32'h0);
    check("t5_rdata_rst",  32'(bus.rdata), 32'h0);
    check("t5_cs_rst",     32'(bus.sram_cs), 32'h0);
    check("t5_we_rst",     32'(bus.sram_we), 32'h0);
    check("t5_addr_rst",   32'(bus.sram_addr), 32'h0);
    set_slot(REQ_LOADER,     1'b0, 12'h010, '0);
    set_slot(REQ_ESTIMATOR,  1'b0, 12'h020, '0);
    set_slot(REQ_SERIALIZER, 1'b0, 12'h030, '0);
    repeat (2) begin
      step();
      check("t5_rvalid_hold", 32'(bus.rvalid), 32'h0);
    end
    rst_n = 1'b1;
    step();
    check("t5_first_gnt",  32'(bus.gnt), 32'h1);
    check("t5_rvalid_rel", 32'(bus.rvalid), 32'h0);

    // Round robin with all three held, each dropping for one cycle
    for (int k = 0; k < 6; k++) begin
      own = k % 3;
      check("rr_gnt", 32'(bus.gnt), 32'(1) << own);
      for (int j = 0; j < 4; j++) begin
        check("rr_cs",   32'(bus.sram_cs), 32'h1);
        check("rr_addr", 32'(bus.sram_addr), 32'((own + 1) * 16));
        step();
      end
      bus.req[own] = 1'b0;
      #1;
      check("rr_drop_cs", 32'(bus.sram_cs), 32'h0);
      step();
      bus.req[own] = 1'b1;
    end
    bus.req = '0;
    step();
    check("rr_idle", 32'(bus.gnt), 32'h0);

    // Burst cap: estimator revoked after MB contended cycles
    bus.req = 3'b010;
    step();
    check("cap_gnt_est", 32'(bus.gnt), 32'h2);
    step();
    bus.req = 3'b011;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("cap_hold_gnt", 32'(bus.gnt), 32'h2);
      check("cap_hold_cs",  32'(bus.sram_cs), 32'h1);
      step();
    end
    check("cap_revoke", 32'(bus.gnt), 32'h1);
    step();
    step();
    bus.req = 3'b010;
    #1;
    check("cap_drop_cs", 32'(bus.sram_cs), 32'h0);
    step();
    check("cap_regrant", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    check("cap_idle", 32'(bus.gnt), 32'h0);

    // Owner drop coincides with a new serializer request
    bus.req = 3'b001;
    step();
    check("sim_gnt_ld", 32'(bus.gnt), 32'h1);
    #1;
    check("sim_cs_ld", 32'(bus.sram_cs), 32'h1);
    step();
    bus.req = 3'b100;
    step();
    check("sim_gnt_ser", 32'(bus.gnt), 32'h4);
    #1;
    check("sim_cs_ser",   32'(bus.sram_cs), 32'h1);
    check("sim_addr_ser", 32'(bus.sram_addr), 32'h030);
    bus.req = '0;
    step();
    check("sim_idle", 32'(bus.gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
